// File: rtl/frame_buf_ring.sv
// Ring of NUM_BUFS whole-frame buffers between a pixel producer and a consumer.
// Frames are committed only when complete and released only once fully read.
module frame_buf_ring #(
  parameter int DATA_WIDTH    = 24,
  parameter int ADDR_WIDTH    = 3,
  parameter int BUF_SEL_WIDTH = 1,
  parameter int DROP_ON_FULL  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en_in,
  input  logic [DATA_WIDTH-1:0]    data_in,
  output logic                     wr_rdy,
  output logic                     overflow,
  input  logic                     rd_en_in,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     rd_valid,
  output logic                     frame_start,
  output logic                     rd_frame_done,
  output logic [BUF_SEL_WIDTH:0]   frames_avail
);

  localparam int MEM_DEPTH = 1 << (BUF_SEL_WIDTH + ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR = '1;
  localparam logic [BUF_SEL_WIDTH:0] FULL_CNT  = {1'b1, {BUF_SEL_WIDTH{1'b0}}};

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wr_state_t;
  typedef enum logic       {R_IDLE, R_READ}         rd_state_t;

  wr_state_t wr_state;
  rd_state_t rd_state;

  logic [DATA_WIDTH-1:0]    mem [MEM_DEPTH];
  logic [BUF_SEL_WIDTH-1:0] wr_buf, rd_buf;
  logic [ADDR_WIDTH-1:0]    wr_addr, rd_addr;
  logic full, wr_store, commit, rd_fire, rd_release;

  // Handshake: a write beat transfers on a clock edge where wr_en_in && wr_rdy.
  // wr_rdy depends only on registered state, never on wr_en_in.
  always_comb begin
    full       = (frames_avail == FULL_CNT);
    wr_rdy     = (DROP_ON_FULL != 0) || (wr_state != W_IDLE) || !full;
    wr_store   = wr_en_in && ((wr_state == W_IDLE && !full) || wr_state == W_FILL);
    commit     = wr_en_in && (wr_state == W_FILL) && (wr_addr == LAST_ADDR);
    rd_fire    = rd_en_in && ((rd_state == R_READ) || (frames_avail != '0));
    rd_release = rd_en_in && (rd_state == R_READ) && (rd_addr == LAST_ADDR);
  end

  // Addresses sit at zero whenever an FSM is idle, so {buf,addr} is always the target.
  always_ff @(posedge clk) begin
    if (wr_store) mem[{wr_buf, wr_addr}] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state <= W_IDLE;
      wr_buf   <= '0;
      wr_addr  <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= 1'b0;
      case (wr_state)
        W_IDLE: begin
          if (wr_en_in && !full) begin
            wr_addr  <= wr_addr + ADDR_WIDTH'(1);
            wr_state <= W_FILL;
          end else if (wr_en_in && DROP_ON_FULL != 0) begin
            overflow <= 1'b1;
            wr_addr  <= wr_addr + ADDR_WIDTH'(1);
            wr_state <= W_DROP;
          end
        end
        W_FILL: begin
          if (wr_en_in) begin
            wr_addr <= wr_addr + ADDR_WIDTH'(1);
            if (wr_addr == LAST_ADDR) begin
              wr_buf   <= wr_buf + BUF_SEL_WIDTH'(1);
              wr_state <= W_IDLE;
            end
          end
        end
        W_DROP: begin
          if (wr_en_in) begin
            wr_addr <= wr_addr + ADDR_WIDTH'(1);
            if (wr_addr == LAST_ADDR) wr_state <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state      <= R_IDLE;
      rd_buf        <= '0;
      rd_addr       <= '0;
      rd_valid      <= 1'b0;
      frame_start   <= 1'b0;
      rd_frame_done <= 1'b0;
      data_out      <= '0;
    end else begin
      rd_valid      <= rd_fire;
      frame_start   <= rd_fire && (rd_state == R_IDLE);
      rd_frame_done <= rd_release;
      if (rd_fire) begin
        data_out <= mem[{rd_buf, rd_addr}];
        rd_addr  <= rd_addr + ADDR_WIDTH'(1);
      end
      case (rd_state)
        R_IDLE: if (rd_fire) rd_state <= R_READ;
        R_READ: begin
          if (rd_release) begin
            rd_buf   <= rd_buf + BUF_SEL_WIDTH'(1);
            rd_state <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  // The frame being read stays counted until release, so the writer can never reach it.
  always_ff @(posedge clk) begin
    if (reset) begin
      frames_avail <= '0;
    end else begin
      case ({commit, rd_release})
        2'b10:   frames_avail <= frames_avail + (BUF_SEL_WIDTH+1)'(1);
        2'b01:   frames_avail <= frames_avail - (BUF_SEL_WIDTH+1)'(1);
        default: frames_avail <= frames_avail;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_buf_ring.sv
// Bench for frame_buf_ring: instance a drops on full, instance b stalls the writer.
// Read data is checked against a queue of expected {start, done, data} words.
module tb_frame_buf_ring;

  localparam int DW = 24;

  logic clk, reset, sel;
  logic [DW-1:0] data_in;
  logic wr_en_a, rd_en_a, wr_en_b, rd_en_b;
  logic wr_rdy_a, overflow_a, rd_valid_a, frame_start_a, rd_frame_done_a;
  logic wr_rdy_b, overflow_b, rd_valid_b, frame_start_b, rd_frame_done_b;
  logic [DW-1:0] data_out_a, data_out_b;
  logic [1:0] frames_avail_a, frames_avail_b;

  logic cur_wr_rdy, cur_overflow, cur_rd_valid, cur_frame_start, cur_rd_frame_done;
  logic [DW-1:0] cur_data_out;
  logic [1:0] cur_frames_avail;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW+1:0] exp_q[$];

  typedef struct {
    logic          wr;
    logic [DW-1:0] d;
    logic          rd;
    logic [1:0]    exp_avail;
    logic          exp_rdy;
    logic          exp_valid;
  } vec_t;
  vec_t vecs[16];

  frame_buf_ring #(.DATA_WIDTH(DW), .ADDR_WIDTH(3), .BUF_SEL_WIDTH(1), .DROP_ON_FULL(1)) dut_a (
    .clk(clk), .reset(reset), .wr_en_in(wr_en_a), .data_in(data_in), .wr_rdy(wr_rdy_a),
    .overflow(overflow_a), .rd_en_in(rd_en_a), .data_out(data_out_a), .rd_valid(rd_valid_a),
    .frame_start(frame_start_a), .rd_frame_done(rd_frame_done_a), .frames_avail(frames_avail_a));

  frame_buf_ring #(.DATA_WIDTH(DW), .ADDR_WIDTH(3), .BUF_SEL_WIDTH(1), .DROP_ON_FULL(0)) dut_b (
    .clk(clk), .reset(reset), .wr_en_in(wr_en_b), .data_in(data_in), .wr_rdy(wr_rdy_b),
    .overflow(overflow_b), .rd_en_in(rd_en_b), .data_out(data_out_b), .rd_valid(rd_valid_b),
    .frame_start(frame_start_b), .rd_frame_done(rd_frame_done_b), .frames_avail(frames_avail_b));

  always_comb begin
    cur_wr_rdy        = sel ? wr_rdy_b        : wr_rdy_a;
    cur_overflow      = sel ? overflow_b      : overflow_a;
    cur_rd_valid      = sel ? rd_valid_b      : rd_valid_a;
    cur_frame_start   = sel ? frame_start_b   : frame_start_a;
    cur_rd_frame_done = sel ? rd_frame_done_b : rd_frame_done_a;
    cur_data_out      = sel ? data_out_b      : data_out_a;
    cur_frames_avail  = sel ? frames_avail_b  : frames_avail_a;
  end

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard
  task automatic sb_sample();
    logic [DW+1:0] e;
    if (cur_rd_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got rd_valid with data %0h expected no read", cur_data_out);
      end else begin
        e = exp_q.pop_front();
        check("sb_data", cur_data_out, e[DW-1:0]);
        check("sb_frame_start", cur_frame_start, e[DW+1]);
        check("sb_frame_done", cur_rd_frame_done, e[DW]);
      end
    end
  endtask

  task automatic push_frame(input logic [DW-1:0] base);
    for (int i = 0; i < 8; i++)
      exp_q.push_back({(i == 0), (i == 7), base + DW'(i)});
  endtask

  // drivers
  task automatic set_in(input logic w, input logic [DW-1:0] d, input logic r);
    data_in = d;
    wr_en_a = w && !sel;
    wr_en_b = w && sel;
    rd_en_a = r && !sel;
    rd_en_b = r && sel;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    sb_sample();
  endtask

  task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r);
    set_in(w, d, r);
    step();
    set_in(1'b0, '0, 1'b0);
  endtask

  task automatic read_words(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b1);
  endtask

  task automatic write_frame(input logic [DW-1:0] base, output int ovf);
    int budget;
    ovf = 0;
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, base + DW'(i), 1'b0);
      budget = 0;
      while (!cur_wr_rdy && budget < 200) begin
        step();
        budget++;
      end
      if (budget >= 200) check("wr_rdy_timeout", cur_wr_rdy, 1);
      step();
      ovf += int'(cur_overflow);
    end
    set_in(1'b0, '0, 1'b0);
  endtask

  initial begin
    int ovf, wc, rc;
    logic w, r;
    logic [DW-1:0] fa, fb, fc;

    sel = 1'b0;
    reset = 1'b1;
    set_in(1'b0, '0, 1'b0);
    step();
    step();
    reset = 1'b0;

    // reset state
    check("rst_wr_rdy", wr_rdy_a, 1);
    check("rst_overflow", overflow_a, 0);
    check("rst_rd_valid", rd_valid_a, 0);
    check("rst_frame_start", frame_start_a, 0);
    check("rst_frame_done", rd_frame_done_a, 0);
    check("rst_data_out", data_out_a, 0);
    check("rst_avail_a", frames_avail_a, 0);
    check("rst_avail_b", frames_avail_b, 0);
    check("rst_wr_rdy_b", wr_rdy_b, 1);

    // basic frame through a table of per-cycle vectors
    for (int i = 0; i < 16; i++) begin
      vecs[i].wr        = (i < 8);
      vecs[i].d         = (i < 8) ? DW'(i + 1) : '0;
      vecs[i].rd        = (i >= 8);
      vecs[i].exp_avail = (i == 7 || (i >= 8 && i < 15)) ? 2'd1 : 2'd0;
      vecs[i].exp_rdy   = 1'b1;
      vecs[i].exp_valid = (i >= 8);
    end
    push_frame(24'h000001);
    for (int i = 0; i < 16; i++) begin
      set_in(vecs[i].wr, vecs[i].d, vecs[i].rd);
      step();
      check($sformatf("vec%0d_avail", i), cur_frames_avail, vecs[i].exp_avail);
      check($sformatf("vec%0d_wr_rdy", i), cur_wr_rdy, vecs[i].exp_rdy);
      check($sformatf("vec%0d_rd_valid", i), cur_rd_valid, vecs[i].exp_valid);
    end
    cyc(1'b0, '0, 1'b0);

    // drop on full: third frame discarded with a single overflow pulse
    fa = 24'h00A000; fb = 24'h00B000; fc = 24'h00C000;
    write_frame(fa, ovf); push_frame(fa);
    write_frame(fb, ovf); push_frame(fb);
    check("drop_avail_full", cur_frames_avail, 2);
    check("drop_no_ovf_before", ovf, 0);
    write_frame(fc, ovf);
    check("drop_ovf_pulses", ovf, 1);
    check("drop_avail_kept", cur_frames_avail, 2);
    step();
    check("drop_ovf_low", cur_overflow, 0);
    read_words(16);
    cyc(1'b0, '0, 1'b0);
    check("drop_avail_drained", cur_frames_avail, 0);

    // stall on full: writer held until the oldest frame is released
    sel = 1'b1;
    fa = 24'h0A0100; fb = 24'h0B0100; fc = 24'h0C0100;
    write_frame(fa, ovf); push_frame(fa);
    write_frame(fb, ovf); push_frame(fb);
    set_in(1'b1, fc, 1'b0);
    step();
    step();
    check("stall_wr_rdy_low", cur_wr_rdy, 0);
    check("stall_avail", cur_frames_avail, 2);
    for (int k = 0; k < 8; k++) begin
      set_in(1'b1, fc, 1'b1);
      step();
      if (k == 6) check("stall_rdy_before_release", cur_wr_rdy, 0);
    end
    set_in(1'b1, fc, 1'b0);
    check("stall_rdy_after_release", cur_wr_rdy, 1);
    check("stall_avail_after_release", cur_frames_avail, 1);
    write_frame(fc, ovf); push_frame(fc);
    check("stall_no_ovf", ovf, 0);
    read_words(16);
    cyc(1'b0, '0, 1'b0);
    check("stall_avail_drained", cur_frames_avail, 0);
    sel = 1'b0;

    // interleaved writes and reads on alternate cycles, random frame contents
    fa = DW'($urandom_range(0, 32'h00FF_FF00));
    fb = DW'($urandom_range(0, 32'h00FF_FF00));
    write_frame(fa, ovf); push_frame(fa);
    push_frame(fb);
    wc = 0; rc = 0;
    for (int c = 0; c < 32; c++) begin
      w = (c % 2 == 0) && (wc < 8);
      r = (c % 2 == 1) && (rc < 16);
      cyc(w, fb + DW'(wc), r);
      if (w) wc++;
      if (r) rc++;
    end
    cyc(1'b0, '0, 1'b0);
    check("toggle_avail", cur_frames_avail, 0);

    // commit of one frame on the same edge as release of another
    fa = 24'h055000; fb = 24'h066000;
    write_frame(fa, ovf); push_frame(fa);
    push_frame(fb);
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, fb + DW'(i), 1'b0);
      cyc(1'b0, '0, 1'b1);
    end
    check("same_cycle_avail_before", cur_frames_avail, 1);
    cyc(1'b1, fb + DW'(7), 1'b1);
    check("same_cycle_avail", cur_frames_avail, 1);
    read_words(8);
    cyc(1'b0, '0, 1'b0);
    check("same_cycle_drained", cur_frames_avail, 0);

    // reset in the middle of a frame discards it
    fa = 24'h077000;
    for (int i = 0; i < 4; i++) cyc(1'b1, fa + DW'(i), 1'b0);
    reset = 1'b1;
    set_in(1'b1, fa + DW'(4), 1'b0);
    step();
    step();
    reset = 1'b0;
    set_in(1'b0, '0, 1'b0);
    read_words(3);
    cyc(1'b0, '0, 1'b0);
    check("midreset_avail", cur_frames_avail, 0);
    check("midreset_data_out", cur_data_out, 0);
    check("midreset_wr_rdy", cur_wr_rdy, 1);
    fb = 24'h088000;
    write_frame(fb, ovf); push_frame(fb);
    check("midreset_new_avail", cur_frames_avail, 1);
    read_words(8);
    cyc(1'b0, '0, 1'b0);
    check("midreset_drained", cur_frames_avail, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
